// File: rtl/cpu_pkg.sv
// Shared encodings for the microcoded CPU controller: state numbers, opcode
// classes, ALU function codes and the flag-register layout.
package cpu_pkg;

   localparam logic [4:0] StFetch0 = 5'd0;
   localparam logic [4:0] StFetch1 = 5'd1;
   localparam logic [4:0] StFetch2 = 5'd2;
   localparam logic [4:0] StFetch3 = 5'd3;
   localparam logic [4:0] StFetch4 = 5'd4;
   localparam logic [4:0] StDecode = 5'd5;
   localparam logic [4:0] StAluRx  = 5'd6;
   localparam logic [4:0] StAluRy  = 5'd7;
   localparam logic [4:0] StAluExe = 5'd8;
   localparam logic [4:0] StAluWb  = 5'd9;
   localparam logic [4:0] StLdAddr = 5'd10;
   localparam logic [4:0] StLdMar  = 5'd11;
   localparam logic [4:0] StLdMem  = 5'd12;
   localparam logic [4:0] StLdPass = 5'd13;
   localparam logic [4:0] StLdWb   = 5'd14;
   localparam logic [4:0] StStAddr = 5'd15;
   localparam logic [4:0] StStMar  = 5'd16;
   localparam logic [4:0] StStData = 5'd17;
   localparam logic [4:0] StStMdr  = 5'd18;
   localparam logic [4:0] StStWr   = 5'd19;
   localparam logic [4:0] StBrChk  = 5'd20;
   localparam logic [4:0] StBrAdd  = 5'd21;
   localparam logic [4:0] StBrPc   = 5'd22;
   localparam logic [4:0] StHalt   = 5'd23;

   localparam logic [2:0] ClsLoad   = 3'b000;
   localparam logic [2:0] ClsStore  = 3'b001;
   localparam logic [2:0] ClsAlu    = 3'b011;
   localparam logic [2:0] ClsBranch = 3'b100;
   localparam logic [2:0] ClsHalt   = 3'b111;

   localparam logic [2:0] FselAdd   = 3'b000;
   localparam logic [2:0] FselSub   = 3'b001;
   localparam logic [2:0] FselAnd   = 3'b010;
   localparam logic [2:0] FselOr    = 3'b011;
   localparam logic [2:0] FselXor   = 3'b100;
   localparam logic [2:0] FselNot   = 3'b101;
   localparam logic [2:0] FselPassX = 3'b110;
   localparam logic [2:0] FselInc   = 3'b111;

   typedef struct packed {
      logic c;
      logic v;
      logic s;
      logic z;
   } flags_t;

   // sub[1:0] picks Z/C/S/V, sub[2] inverts the sense of the test.
   function automatic logic branch_cond(flags_t f, logic [2:0] sub);
      logic sel;
      case (sub[1:0])
         2'b00:   sel = f.z;
         2'b01:   sel = f.c;
         2'b10:   sel = f.s;
         default: sel = f.v;
      endcase
      return sel ^ sub[2];
   endfunction

endpackage

// File: rtl/cpu_controller.sv
// Microcoded control unit: decodes the externally held state plus opcode into
// datapath strobes and the next state, and keeps the ALU flag register.
module cpu_controller
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       C,
   input  logic       V,
   input  logic       S,
   input  logic       Z_det,
   input  logic [6:0] opc,
   input  logic [2:0] opd1,
   input  logic [2:0] opd2,
   input  logic [2:0] opd3,
   input  logic [4:0] state,
   output logic [4:0] next_state,
   output logic       ldPC,
   output logic       ldIR,
   output logic       ldMAR,
   output logic       ldtmp,
   output logic       ldMDRZ,
   output logic       ldMDRdata,
   output logic       ldALU,
   output logic       rd_mem,
   output logic       wr_mem,
   output logic       rd_reg,
   output logic       wr_reg,
   output logic       ldXPC,
   output logic       ldYPC,
   output logic       ldXtmp,
   output logic       ldYtmp,
   output logic       ldXreg,
   output logic       ldYreg,
   output logic       ldXmem,
   output logic       ldYmem,
   output logic       ldXtmp2,
   output logic       ldYtmp2,
   output logic [2:0] wr_regA,
   output logic [2:0] rd_regA,
   output logic [2:0] fsel
);

   flags_t flags_d, flags_q;
   logic   unused_opc;

   assign unused_opc = opc[3];

   assign ldYPC   = 1'b0;
   assign ldXtmp  = 1'b0;
   assign ldYtmp  = 1'b0;
   assign ldYmem  = 1'b0;
   assign ldXtmp2 = 1'b0;
   assign ldYtmp2 = 1'b0;

   // Flags are captured from the ALU only on the execute step of a register op.
   always_comb begin
      flags_d = flags_q;
      if (state == StAluExe) begin
         flags_d = '{c: C, v: V, s: S, z: Z_det};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   always_comb begin
      next_state = StFetch0;
      ldPC       = 1'b0;
      ldIR       = 1'b0;
      ldMAR      = 1'b0;
      ldtmp      = 1'b0;
      ldMDRZ     = 1'b0;
      ldMDRdata  = 1'b0;
      ldALU      = 1'b0;
      rd_mem     = 1'b0;
      wr_mem     = 1'b0;
      rd_reg     = 1'b0;
      wr_reg     = 1'b0;
      ldXPC      = 1'b0;
      ldXreg     = 1'b0;
      ldYreg     = 1'b0;
      ldXmem     = 1'b0;
      wr_regA    = 3'd0;
      rd_regA    = 3'd0;
      fsel       = 3'd0;
      if (reset) begin
         case (state)
            StFetch0: begin next_state = StFetch1; ldMAR = 1'b1; rd_mem = 1'b1; end
            StFetch1: begin next_state = StFetch2; rd_mem = 1'b1; ldMDRdata = 1'b1; end
            StFetch2: begin next_state = StFetch3; ldIR = 1'b1; end
            StFetch3: begin
               next_state = StFetch4;
               ldXPC      = 1'b1;
               fsel       = FselInc;
               ldALU      = 1'b1;
            end
            StFetch4: begin next_state = StDecode; ldPC = 1'b1; end
            StDecode: begin
               case (opc[6:4])
                  ClsAlu:    next_state = StAluRx;
                  ClsLoad:   next_state = StLdAddr;
                  ClsStore:  next_state = StStAddr;
                  ClsBranch: next_state = StBrChk;
                  ClsHalt:   next_state = StHalt;
                  default:   next_state = StFetch0;
               endcase
            end
            StAluRx: begin
               next_state = StAluRy;
               rd_reg     = 1'b1;
               rd_regA    = opd2;
               ldXreg     = 1'b1;
            end
            StAluRy: begin
               next_state = StAluExe;
               rd_reg     = 1'b1;
               rd_regA    = opd3;
               ldYreg     = 1'b1;
            end
            StAluExe: begin next_state = StAluWb; fsel = opc[2:0]; ldALU = 1'b1; end
            StAluWb:  begin wr_reg = 1'b1; wr_regA = opd1; end
            // Address pass-through is shared by LOAD and STORE.
            StLdAddr, StStAddr: begin
               next_state = (state == StLdAddr) ? StLdMar : StStMar;
               rd_reg     = 1'b1;
               rd_regA    = opd2;
               ldXreg     = 1'b1;
               fsel       = FselPassX;
               ldALU      = 1'b1;
            end
            StLdMar:  begin next_state = StLdMem; ldMAR = 1'b1; rd_mem = 1'b1; end
            StLdMem:  begin next_state = StLdPass; rd_mem = 1'b1; ldMDRdata = 1'b1; end
            StLdPass: begin
               next_state = StLdWb;
               ldXmem     = 1'b1;
               fsel       = FselPassX;
               ldALU      = 1'b1;
            end
            StLdWb:   begin wr_reg = 1'b1; wr_regA = opd1; end
            StStMar:  begin next_state = StStData; ldMAR = 1'b1; end
            StStData: begin
               next_state = StStMdr;
               rd_reg     = 1'b1;
               rd_regA    = opd1;
               ldtmp      = 1'b1;
            end
            StStMdr:  begin next_state = StStWr; ldMDRZ = 1'b1; end
            StStWr:   wr_mem = 1'b1;
            StBrChk: begin
               if (branch_cond(flags_q, opc[2:0])) begin
                  next_state = StBrAdd;
                  ldXPC      = 1'b1;
                  rd_reg     = 1'b1;
                  rd_regA    = opd1;
                  ldYreg     = 1'b1;
               end
            end
            StBrAdd:  begin next_state = StBrPc; fsel = FselAdd; ldALU = 1'b1; end
            StBrPc:   ldPC = 1'b1;
            StHalt:   next_state = StHalt;
            default:  next_state = StFetch0;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench: builds each instruction's expected micro-step list from
// its class and compares the controller cycle by cycle with a fed-back state.
module tb_cpu_controller;

   typedef struct packed {
      logic [4:0] ns;
      logic       ld_pc, ld_ir, ld_mar, ld_tmp, ld_mdrz, ld_mdrdata, ld_alu;
      logic       rdm, wrm, rdr, wrr;
      logic [9:0] sel;   // XPC YPC Xtmp Ytmp Xreg Yreg Xmem Ymem Xtmp2 Ytmp2
      logic [2:0] wra, rda, fs;
   } vec_t;

   localparam int XPC = 9, XREG = 5, YREG = 4, XMEM = 3;

   logic       clk = 1'b0;
   logic       reset, C, V, S, Z_det;
   logic [6:0] opc;
   logic [2:0] opd1, opd2, opd3;
   logic [4:0] state;
   logic [4:0] next_state;
   logic       ldPC, ldIR, ldMAR, ldtmp, ldMDRZ, ldMDRdata, ldALU;
   logic       rd_mem, wr_mem, rd_reg, wr_reg;
   logic       ldXPC, ldYPC, ldXtmp, ldYtmp, ldXreg, ldYreg, ldXmem, ldYmem, ldXtmp2, ldYtmp2;
   logic [2:0] wr_regA, rd_regA, fsel;

   int   checks = 0;
   int   errors = 0;
   logic mz = 0, mc = 0, ms = 0, mv = 0;   // model flag register
   vec_t exp_q[$];
   int   st_q[$];

   always #5 clk = ~clk;

   cpu_controller dut (
      .clk(clk), .reset(reset), .C(C), .V(V), .S(S), .Z_det(Z_det),
      .opc(opc), .opd1(opd1), .opd2(opd2), .opd3(opd3), .state(state),
      .next_state(next_state), .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldtmp(ldtmp),
      .ldMDRZ(ldMDRZ), .ldMDRdata(ldMDRdata), .ldALU(ldALU), .rd_mem(rd_mem),
      .wr_mem(wr_mem), .rd_reg(rd_reg), .wr_reg(wr_reg), .ldXPC(ldXPC), .ldYPC(ldYPC),
      .ldXtmp(ldXtmp), .ldYtmp(ldYtmp), .ldXreg(ldXreg), .ldYreg(ldYreg),
      .ldXmem(ldXmem), .ldYmem(ldYmem), .ldXtmp2(ldXtmp2), .ldYtmp2(ldYtmp2),
      .wr_regA(wr_regA), .rd_regA(rd_regA), .fsel(fsel)
   );

   function automatic vec_t observe();
      vec_t v;
      v.ns = next_state;
      {v.ld_pc, v.ld_ir, v.ld_mar, v.ld_tmp, v.ld_mdrz, v.ld_mdrdata, v.ld_alu} =
         {ldPC, ldIR, ldMAR, ldtmp, ldMDRZ, ldMDRdata, ldALU};
      {v.rdm, v.wrm, v.rdr, v.wrr} = {rd_mem, wr_mem, rd_reg, wr_reg};
      v.sel = {ldXPC, ldYPC, ldXtmp, ldYtmp, ldXreg, ldYreg, ldXmem, ldYmem, ldXtmp2, ldYtmp2};
      v.wra = wr_regA;
      v.rda = rd_regA;
      v.fs  = fsel;
      return v;
   endfunction

   function automatic vec_t blank(int ns);
      vec_t v = '0;
      v.ns = ns[4:0];
      return v;
   endfunction

   task automatic check(input string tag, input int st, input vec_t got, input vec_t want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s state=%0d observed=%h expected=%h", tag, st, got, want);
      end
   endtask

   task automatic push(input int st, input vec_t v);
      st_q.push_back(st);
      exp_q.push_back(v);
   endtask

   // Expected micro-step list for one instruction, written from its class semantics.
   task automatic build(input logic [6:0] op, input logic [2:0] d1, d2, d3);
      vec_t v;
      logic [2:0] cls = op[6:4];
      logic [3:0] fl;
      logic cond;
      exp_q.delete();
      st_q.delete();
      v = blank(1); v.ld_mar = 1; v.rdm = 1; push(0, v);
      v = blank(2); v.rdm = 1; v.ld_mdrdata = 1; push(1, v);
      v = blank(3); v.ld_ir = 1; push(2, v);
      v = blank(4); v.sel[XPC] = 1; v.fs = 3'b111; v.ld_alu = 1; push(3, v);
      v = blank(5); v.ld_pc = 1; push(4, v);
      case (cls)
         3'b011: begin
            push(5, blank(6));
            v = blank(7); v.rdr = 1; v.rda = d2; v.sel[XREG] = 1; push(6, v);
            v = blank(8); v.rdr = 1; v.rda = d3; v.sel[YREG] = 1; push(7, v);
            v = blank(9); v.fs = op[2:0]; v.ld_alu = 1; push(8, v);
            v = blank(0); v.wrr = 1; v.wra = d1; push(9, v);
         end
         3'b000: begin
            push(5, blank(10));
            v = blank(11); v.rdr = 1; v.rda = d2; v.sel[XREG] = 1; v.fs = 3'b110;
            v.ld_alu = 1; push(10, v);
            v = blank(12); v.ld_mar = 1; v.rdm = 1; push(11, v);
            v = blank(13); v.rdm = 1; v.ld_mdrdata = 1; push(12, v);
            v = blank(14); v.sel[XMEM] = 1; v.fs = 3'b110; v.ld_alu = 1; push(13, v);
            v = blank(0); v.wrr = 1; v.wra = d1; push(14, v);
         end
         3'b001: begin
            push(5, blank(15));
            v = blank(16); v.rdr = 1; v.rda = d2; v.sel[XREG] = 1; v.fs = 3'b110;
            v.ld_alu = 1; push(15, v);
            v = blank(17); v.ld_mar = 1; push(16, v);
            v = blank(18); v.rdr = 1; v.rda = d1; v.ld_tmp = 1; push(17, v);
            v = blank(19); v.ld_mdrz = 1; push(18, v);
            v = blank(0); v.wrm = 1; push(19, v);
         end
         3'b100: begin
            push(5, blank(20));
            fl   = {mv, ms, mc, mz};         // index 0 Z, 1 C, 2 S, 3 V
            cond = fl[op[1:0]] ^ op[2];
            if (cond) begin
               v = blank(21); v.sel[XPC] = 1; v.rdr = 1; v.rda = d1; v.sel[YREG] = 1;
               push(20, v);
               v = blank(22); v.fs = 3'b000; v.ld_alu = 1; push(21, v);
               v = blank(0); v.ld_pc = 1; push(22, v);
            end else begin
               push(20, blank(0));
            end
         end
         3'b111: begin
            push(5, blank(23));
            for (int k = 0; k < 3; k++) push(23, blank(23));
         end
         default: push(5, blank(0));
      endcase
   endtask

   task automatic do_reset(input logic [4:0] st);
      reset = 1'b0;
      state = st;
      #1;
      check("reset", st, observe(), blank(0));
      @(posedge clk);
      #1;
      check("reset_hold", st, observe(), blank(0));
      reset = 1'b1;
      state = 5'd0;
      {mc, mv, ms, mz} = 4'b0000;
   endtask

   // abort_at < 0 runs to completion; otherwise reset is asserted after that step.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] d1, d2, d3,
                            input logic [3:0] cvsz, input int abort_at);
      logic [4:0] ns_cap;
      opc = op; opd1 = d1; opd2 = d2; opd3 = d3;
      {C, V, S, Z_det} = cvsz;
      build(op, d1, d2, d3);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         check("step", st_q[i], observe(), exp_q[i]);
         ns_cap = next_state;
         if (i == abort_at) begin
            do_reset(state);
            return;
         end
         @(posedge clk);
         #1 state = ns_cap;
      end
      if (op[6:4] == 3'b011) {mc, mv, ms, mz} = cvsz;
      if (op[6:4] == 3'b111) do_reset(state);
   endtask

   initial begin
      int n;
      logic [2:0] cls;
      reset = 1'b0; state = 5'd0; opc = '0; opd1 = '0; opd2 = '0; opd3 = '0;
      {C, V, S, Z_det} = 4'b0000;
      @(negedge clk);
      do_reset(5'd9);

      run_instr(7'b0110000, 3'd0, 3'd0, 3'd0, 4'b0000, -1);
      run_instr(7'b0000000, 3'd3, 3'd5, 3'd0, 4'b1111, -1);
      run_instr(7'b0010000, 3'd3, 3'd5, 3'd0, 4'b1111, -1);
      run_instr(7'b0110001, 3'd1, 3'd2, 3'd3, 4'b0001, -1);   // Z latched 1
      run_instr(7'b1000000, 3'd2, 3'd0, 3'd0, 4'b0000, -1);   // taken
      run_instr(7'b0110010, 3'd4, 3'd5, 3'd6, 4'b1110, -1);   // Z latched 0
      run_instr(7'b1000000, 3'd2, 3'd0, 3'd0, 4'b0001, -1);   // not taken
      run_instr(7'b1000101, 3'd7, 3'd0, 3'd0, 4'b0000, -1);   // C=1 inverted: not taken
      run_instr(7'b0110011, 3'd5, 3'd1, 3'd2, 4'b0001, 9);    // abort before write-back
      run_instr(7'b1000000, 3'd1, 3'd0, 3'd0, 4'b0000, -1);   // flags cleared: not taken
      run_instr(7'b1000100, 3'd1, 3'd0, 3'd0, 4'b0000, -1);   // flags cleared: not-Z taken
      run_instr(7'b1110000, 3'd0, 3'd0, 3'd0, 4'b0000, -1);

      for (int s = 24; s < 32; s++) begin
         @(negedge clk);
         state = s[4:0];
         #1;
         check("illegal", s, observe(), blank(0));
         state = 5'd0;
      end

      for (int k = 0; k < 80; k++) begin
         n = $urandom_range(0, 11);
         case (n)
            0, 1, 2: cls = 3'b011;
            3, 4:    cls = 3'b000;
            5, 6:    cls = 3'b001;
            7, 8, 9: cls = 3'b100;
            10:      cls = 3'($urandom_range(5, 6));
            default: cls = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'b010;
         endcase
         run_instr({cls, 4'($urandom)}, 3'($urandom), 3'($urandom), 3'($urandom),
                   4'($urandom), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
